// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Package  : mips_pkg
// Purpose  : Shared definitions for the five-stage MIPS-subset pipeline:
//            opcode / funct encodings, the nop word, the ALU operation enum,
//            the decoded control bundle and the ALU evaluation function.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mips_pkg;

  localparam logic [5:0] c_op_rtype = 6'h00;
  localparam logic [5:0] c_op_j     = 6'h02;
  localparam logic [5:0] c_op_beq   = 6'h04;
  localparam logic [5:0] c_op_bne   = 6'h05;
  localparam logic [5:0] c_op_addi  = 6'h08;
  localparam logic [5:0] c_op_lw    = 6'h23;
  localparam logic [5:0] c_op_sw    = 6'h2b;

  localparam logic [5:0] c_fn_add = 6'h20;
  localparam logic [5:0] c_fn_sub = 6'h22;
  localparam logic [5:0] c_fn_and = 6'h24;
  localparam logic [5:0] c_fn_or  = 6'h25;
  localparam logic [5:0] c_fn_slt = 6'h2a;

  localparam logic [31:0] c_nop = 32'h0000_0000;

  typedef enum logic [2:0] {
    c_alu_add,
    c_alu_sub,
    c_alu_and,
    c_alu_or,
    c_alu_slt
  } alu_op_t;

  // Decoded control carried down the pipe; all-zero is a bubble.
  typedef struct packed {
    logic    regwrite;
    logic    memtoreg;
    logic    memread;
    logic    memwrite;
    logic    beq;
    logic    bne;
    logic    alusrc;
    alu_op_t aluop;
  } ctrl_t;

  function automatic logic [31:0] alu_eval(input alu_op_t op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
    logic [31:0] y;
    case (op)
      c_alu_add: y = a + b;
      c_alu_sub: y = a - b;
      c_alu_and: y = a & b;
      c_alu_or:  y = a | b;
      c_alu_slt: y = {31'b0, ($signed(a) < $signed(b))};
      default:   y = a + b;
    endcase
    return y;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mips_mem_if.sv
`default_nettype none
// ============================================================================
// Interface: mips_mem_if
// Purpose  : Word memory access bus (byte address, combinational read data,
//            write strobe sampled at the clock edge).
// Ports    : master - drives addr/wdata/we, receives rdata
//            slave  - receives addr/wdata/we, drives rdata
// Revision : 1.0 - initial release
// ============================================================================
interface mips_mem_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic [31:0] rdata;

  modport master (output addr, output wdata, output we, input rdata);
  modport slave  (input addr, input wdata, input we, output rdata);
endinterface
`default_nettype wire

// File: rtl/mips_mem.sv
`default_nettype none
// ============================================================================
// Module   : mips_mem
// Purpose  : Word-organised memory, synchronous write / asynchronous read.
//            The array is never reset so preloaded contents persist.
// Ports    : clk - write clock
//            bus - mips_mem_if slave (byte address, word index addr[AW+1:2])
// Revision : 1.0 - initial release
// ============================================================================
module mips_mem #(
  parameter int WORDS = 64
) (
  input logic       clk,
  mips_mem_if.slave bus
);

  localparam int c_aw = $clog2(WORDS);

  logic [31:0] data [WORDS];
  logic        w_unused_addr;

  always_ff @(posedge clk) begin
    if (bus.we) data[bus.addr[c_aw+1:2]] <= bus.wdata;
  end

  assign bus.rdata = data[bus.addr[c_aw+1:2]];

  // Byte-offset and high address bits do not select a word.
  assign w_unused_addr = ^{bus.addr[31:c_aw+2], bus.addr[1:0]};

endmodule
`default_nettype wire

// File: rtl/mips_top.sv
`default_nettype none
// ============================================================================
// Module   : mips_top
// Purpose  : Five-stage pipelined MIPS-subset core (IF/ID/EX/MEM/WB) with
//            forwarding, load-use stall, branches resolved in EX and jumps
//            resolved in ID. Owns instruction memory Ins_Mem and data memory
//            Data_Mem.
// Ports    : clk   - system clock, rising edge
//            reset - asynchronous, active-low
// Revision : 1.0 - initial release
// ============================================================================
module mips_top
  import mips_pkg::*;
#(
  parameter int IMEM_WORDS = 64,
  parameter int DMEM_WORDS = 64
) (
  input logic clk,
  input logic reset
);

  mips_mem_if imem_if ();
  mips_mem_if dmem_if ();

  mips_mem #(.WORDS(IMEM_WORDS)) Ins_Mem  (.clk(clk), .bus(imem_if));
  mips_mem #(.WORDS(DMEM_WORDS)) Data_Mem (.clk(clk), .bus(dmem_if));

  logic [31:0] r_pc;
  logic [31:0] r_regs [32];
  // IF/ID
  logic [31:0] r_ifid_pc4, r_ifid_instr;
  // ID/EX
  ctrl_t       r_idex_ctrl;
  logic [31:0] r_idex_pc4, r_idex_a, r_idex_b, r_idex_imm;
  logic [4:0]  r_idex_rs, r_idex_rt, r_idex_dest;
  // EX/MEM
  logic        r_exmem_regwrite, r_exmem_memtoreg, r_exmem_memwrite;
  logic [31:0] r_exmem_alu, r_exmem_sdata;
  logic [4:0]  r_exmem_dest;
  // MEM/WB
  logic        r_memwb_regwrite;
  logic [31:0] r_memwb_result;
  logic [4:0]  r_memwb_dest;

  logic [5:0]  w_op, w_fn;
  logic [4:0]  w_rs, w_rt, w_rd, w_dest;
  logic [31:0] w_imm, w_rs_val, w_rt_val, w_jtarget;
  ctrl_t       w_ctrl;
  logic        w_stall, w_jump, w_taken;
  logic [31:0] w_fwd_a, w_fwd_b, w_alu_y, w_br_target, w_mem_result;
  logic        w_unused_bits;

  // ---------------- IF ----------------
  assign imem_if.addr  = r_pc;
  assign imem_if.wdata = '0;
  assign imem_if.we    = 1'b0;

  // ---------------- ID ----------------
  assign w_op  = r_ifid_instr[31:26];
  assign w_rs  = r_ifid_instr[25:21];
  assign w_rt  = r_ifid_instr[20:16];
  assign w_rd  = r_ifid_instr[15:11];
  assign w_fn  = r_ifid_instr[5:0];
  assign w_imm = {{16{r_ifid_instr[15]}}, r_ifid_instr[15:0]};
  assign w_jtarget = {r_ifid_pc4[31:28], r_ifid_instr[25:0], 2'b00};

  always_comb begin
    w_ctrl = '0;
    w_dest = w_rt;
    case (w_op)
      c_op_rtype: begin
        w_dest          = w_rd;
        w_ctrl.regwrite = 1'b1;
        case (w_fn)
          c_fn_add: w_ctrl.aluop = c_alu_add;
          c_fn_sub: w_ctrl.aluop = c_alu_sub;
          c_fn_and: w_ctrl.aluop = c_alu_and;
          c_fn_or:  w_ctrl.aluop = c_alu_or;
          c_fn_slt: w_ctrl.aluop = c_alu_slt;
          default:  w_ctrl.regwrite = 1'b0;  // includes the all-zero nop
        endcase
      end
      c_op_addi: begin
        w_ctrl.regwrite = 1'b1;
        w_ctrl.alusrc   = 1'b1;
      end
      c_op_lw: begin
        w_ctrl.regwrite = 1'b1;
        w_ctrl.memtoreg = 1'b1;
        w_ctrl.memread  = 1'b1;
        w_ctrl.alusrc   = 1'b1;
      end
      c_op_sw: begin
        w_ctrl.memwrite = 1'b1;
        w_ctrl.alusrc   = 1'b1;
      end
      c_op_beq: w_ctrl.beq = 1'b1;
      c_op_bne: w_ctrl.bne = 1'b1;
      default: ;
    endcase
  end

  // Register read with write-through of the value being written back.
  assign w_rs_val = (w_rs == 5'd0) ? 32'd0 :
                    (r_memwb_regwrite && r_memwb_dest == w_rs) ? r_memwb_result : r_regs[w_rs];
  assign w_rt_val = (w_rt == 5'd0) ? 32'd0 :
                    (r_memwb_regwrite && r_memwb_dest == w_rt) ? r_memwb_result : r_regs[w_rt];

  assign w_stall = r_idex_ctrl.memread && (r_idex_rt == w_rs || r_idex_rt == w_rt);
  assign w_jump  = (w_op == c_op_j);

  // ---------------- EX ----------------
  assign w_fwd_a = (r_exmem_regwrite && r_exmem_dest != 5'd0 && r_exmem_dest == r_idex_rs) ? r_exmem_alu :
                   (r_memwb_regwrite && r_memwb_dest != 5'd0 && r_memwb_dest == r_idex_rs) ? r_memwb_result :
                   r_idex_a;
  assign w_fwd_b = (r_exmem_regwrite && r_exmem_dest != 5'd0 && r_exmem_dest == r_idex_rt) ? r_exmem_alu :
                   (r_memwb_regwrite && r_memwb_dest != 5'd0 && r_memwb_dest == r_idex_rt) ? r_memwb_result :
                   r_idex_b;

  assign w_alu_y     = alu_eval(r_idex_ctrl.aluop, w_fwd_a, r_idex_ctrl.alusrc ? r_idex_imm : w_fwd_b);
  assign w_taken     = (r_idex_ctrl.beq && (w_fwd_a == w_fwd_b)) ||
                       (r_idex_ctrl.bne && (w_fwd_a != w_fwd_b));
  assign w_br_target = r_idex_pc4 + {r_idex_imm[29:0], 2'b00};

  // ---------------- MEM ----------------
  assign dmem_if.addr  = r_exmem_alu;
  assign dmem_if.wdata = r_exmem_sdata;
  assign dmem_if.we    = r_exmem_memwrite;
  assign w_mem_result  = r_exmem_memtoreg ? dmem_if.rdata : r_exmem_alu;

  assign w_unused_bits = ^{r_ifid_instr[10:6], r_idex_imm[31:30]};

  // PC and IF/ID: a taken branch wins over a stall, a stall wins over a jump
  // (the held jump is acted on once the stall clears).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc         <= '0;
      r_ifid_pc4   <= '0;
      r_ifid_instr <= c_nop;
    end else if (w_taken) begin
      r_pc         <= w_br_target;
      r_ifid_instr <= c_nop;
    end else if (!w_stall) begin
      if (w_jump) begin
        r_pc         <= w_jtarget;
        r_ifid_instr <= c_nop;
      end else begin
        r_pc         <= r_pc + 32'd4;
        r_ifid_pc4   <= r_pc + 32'd4;
        r_ifid_instr <= imem_if.rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idex_ctrl <= '0;
      r_idex_pc4  <= '0;
      r_idex_a    <= '0;
      r_idex_b    <= '0;
      r_idex_imm  <= '0;
      r_idex_rs   <= '0;
      r_idex_rt   <= '0;
      r_idex_dest <= '0;
    end else begin
      if (w_taken || w_stall) r_idex_ctrl <= '0;
      else                    r_idex_ctrl <= w_ctrl;
      r_idex_pc4  <= r_ifid_pc4;
      r_idex_a    <= w_rs_val;
      r_idex_b    <= w_rt_val;
      r_idex_imm  <= w_imm;
      r_idex_rs   <= w_rs;
      r_idex_rt   <= w_rt;
      r_idex_dest <= w_dest;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_exmem_regwrite <= 1'b0;
      r_exmem_memtoreg <= 1'b0;
      r_exmem_memwrite <= 1'b0;
      r_exmem_alu      <= '0;
      r_exmem_sdata    <= '0;
      r_exmem_dest     <= '0;
      r_memwb_regwrite <= 1'b0;
      r_memwb_result   <= '0;
      r_memwb_dest     <= '0;
    end else begin
      r_exmem_regwrite <= r_idex_ctrl.regwrite;
      r_exmem_memtoreg <= r_idex_ctrl.memtoreg;
      r_exmem_memwrite <= r_idex_ctrl.memwrite;
      r_exmem_alu      <= w_alu_y;
      r_exmem_sdata    <= w_fwd_b;
      r_exmem_dest     <= r_idex_dest;
      r_memwb_regwrite <= r_exmem_regwrite;
      r_memwb_result   <= w_mem_result;
      r_memwb_dest     <= r_exmem_dest;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else if (r_memwb_regwrite && r_memwb_dest != 5'd0) begin
      r_regs[r_memwb_dest] <= r_memwb_result;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mips_top.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_top
// Purpose  : Directed self-checking bench for mips_top: reset behaviour,
//            forwarding, load-use stall, taken branch, bne/j loop, mid-run
//            reset and a counting-sort integration program.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_top;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  int in_vals  [12] = '{1, 3, 5, 7, 9, 2, 4, 6, 8, 0, 0, 0};
  int exp_sort [12] = '{0, 0, 0, 1, 2, 3, 4, 5, 6, 7, 8, 9};

  always #5 clk = ~clk;

  mips_top #(.IMEM_WORDS(64), .DMEM_WORDS(64)) dut (.clk(clk), .reset(reset));

  mips_mem_if probe_if ();
  mips_mem #(.WORDS(4)) u_probe (.clk(clk), .bus(probe_if));

  function automatic logic [31:0] f_r(input logic [4:0] rs, input logic [4:0] rt,
                                      input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] f_i(input logic [5:0] op, input logic [4:0] rs,
                                      input logic [4:0] rt, input int imm);
    logic [31:0] t;
    t = imm;
    return {op, rs, rt, t[15:0]};
  endfunction

  function automatic logic [31:0] f_j(input int word);
    logic [31:0] t;
    t = word;
    return {6'h02, t[25:0]};
  endfunction

  function automatic logic [31:0] sent(input int i);
    return 32'ha5a5_0000 + i;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic init_mems();
    for (int i = 0; i < 64; i++) begin
      dut.Ins_Mem.data[i]  = 32'h0;
      dut.Data_Mem.data[i] = sent(i);
    end
  endtask

  task automatic hold_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_sort();
    dut.Ins_Mem.data[0]  = f_i(6'h08, 0, 9, 48);        // addi $9,$0,48
    dut.Ins_Mem.data[1]  = f_i(6'h23, 1, 2, 0);         // L1: lw $2,0($1)
    dut.Ins_Mem.data[2]  = f_r(2, 2, 3, 6'h20);         // add $3,$2,$2
    dut.Ins_Mem.data[3]  = f_r(3, 3, 3, 6'h20);         // add $3,$3,$3
    dut.Ins_Mem.data[4]  = f_i(6'h23, 3, 4, 96);        // lw $4,96($3)
    dut.Ins_Mem.data[5]  = f_i(6'h08, 4, 4, 1);         // addi $4,$4,1
    dut.Ins_Mem.data[6]  = f_i(6'h2b, 3, 4, 96);        // sw $4,96($3)
    dut.Ins_Mem.data[7]  = f_i(6'h08, 1, 1, 4);         // addi $1,$1,4
    dut.Ins_Mem.data[8]  = f_i(6'h05, 1, 9, -8);        // bne $1,$9,L1
    dut.Ins_Mem.data[9]  = f_i(6'h08, 0, 7, 40);        // addi $7,$0,40
    dut.Ins_Mem.data[10] = f_i(6'h23, 5, 4, 96);        // L2: lw $4,96($5)
    dut.Ins_Mem.data[11] = f_i(6'h04, 4, 0, 4);         // beq $4,$0,SKIP
    dut.Ins_Mem.data[12] = f_i(6'h2b, 6, 8, 48);        // L3: sw $8,48($6)
    dut.Ins_Mem.data[13] = f_i(6'h08, 6, 6, 4);         // addi $6,$6,4
    dut.Ins_Mem.data[14] = f_i(6'h08, 4, 4, -1);        // addi $4,$4,-1
    dut.Ins_Mem.data[15] = f_i(6'h05, 4, 0, -4);        // bne $4,$0,L3
    dut.Ins_Mem.data[16] = f_i(6'h08, 5, 5, 4);         // SKIP: addi $5,$5,4
    dut.Ins_Mem.data[17] = f_i(6'h08, 8, 8, 1);         // addi $8,$8,1
    dut.Ins_Mem.data[18] = f_i(6'h05, 5, 7, -9);        // bne $5,$7,L2
    dut.Ins_Mem.data[19] = f_j(19);                     // j self
  endtask

  initial begin
    probe_if.we    = 1'b0;
    probe_if.addr  = '0;
    probe_if.wdata = '0;

    // ---- reset with preloaded memories ----
    init_mems();
    load_sort();
    for (int i = 0; i < 12; i++) dut.Data_Mem.data[i] = in_vals[i];
    for (int i = 24; i < 34; i++) dut.Data_Mem.data[i] = 32'h0;
    hold_reset();
    check("rst_pc", dut.r_pc, 32'h0);
    check("rst_reg9", dut.r_regs[9], 32'h0);
    check("rst_ifid", dut.r_ifid_instr, 32'h0);
    check("rst_imem4", dut.Ins_Mem.data[4], 32'h8c64_0060);
    for (int i = 0; i < 12; i++)
      check($sformatf("rst_dmem[%0d]", i), dut.Data_Mem.data[i], in_vals[i]);

    // ---- mid-run reset pulse ----
    release_reset();
    run(40);
    #3 reset = 1'b0;
    #1;
    check("midrst_pc", dut.r_pc, 32'h0);
    check("midrst_reg9", dut.r_regs[9], 32'h0);
    for (int i = 24; i < 34; i++) dut.Data_Mem.data[i] = 32'h0;
    repeat (2) @(posedge clk);
    release_reset();

    // ---- integration: counting sort ----
    run(400);
    for (int i = 0; i < 12; i++)
      check($sformatf("sort_out[%0d]", i), dut.Data_Mem.data[12 + i], exp_sort[i]);
    for (int i = 0; i < 12; i++)
      check($sformatf("sort_in[%0d]", i), dut.Data_Mem.data[i], in_vals[i]);
    check("sort_pc_loop", {31'b0, (dut.r_pc == 32'd76 || dut.r_pc == 32'd80)}, 32'd1);

    // ---- forwarding, no stall ----
    hold_reset();
    init_mems();
    dut.Ins_Mem.data[0] = f_i(6'h08, 0, 1, 5);          // addi $1,$0,5
    dut.Ins_Mem.data[1] = f_r(1, 1, 2, 6'h20);          // add $2,$1,$1
    dut.Ins_Mem.data[2] = f_i(6'h2b, 0, 2, 48);         // sw $2,48($0)
    dut.Ins_Mem.data[3] = f_j(3);
    release_reset();
    run(5);
    check("fwd_before", dut.Data_Mem.data[12], sent(12));
    run(1);
    check("fwd_store", dut.Data_Mem.data[12], 32'd10);

    // ---- load-use, one bubble ----
    hold_reset();
    init_mems();
    dut.Data_Mem.data[0] = 32'd1;
    dut.Ins_Mem.data[0] = f_i(6'h23, 0, 3, 0);          // lw $3,0($0)
    dut.Ins_Mem.data[1] = f_i(6'h08, 3, 4, 2);          // addi $4,$3,2
    dut.Ins_Mem.data[2] = f_i(6'h2b, 0, 4, 52);         // sw $4,52($0)
    dut.Ins_Mem.data[3] = f_j(3);
    release_reset();
    run(6);
    check("lu_before", dut.Data_Mem.data[13], sent(13));
    run(1);
    check("lu_store", dut.Data_Mem.data[13], 32'd3);

    // ---- taken branch flushes both shadow instructions ----
    hold_reset();
    init_mems();
    dut.Ins_Mem.data[0] = f_i(6'h04, 0, 0, 2);          // beq $0,$0,+2
    dut.Ins_Mem.data[1] = f_i(6'h08, 0, 5, 1);          // addi $5,$0,1
    dut.Ins_Mem.data[2] = f_i(6'h08, 5, 5, 2);          // addi $5,$5,2
    dut.Ins_Mem.data[3] = f_i(6'h2b, 0, 5, 56);         // sw $5,56($0)
    dut.Ins_Mem.data[4] = f_j(4);
    release_reset();
    run(20);
    check("br_flush", dut.Data_Mem.data[14], 32'd0);

    // ---- bne not taken, j self-loop ----
    hold_reset();
    init_mems();
    dut.Ins_Mem.data[0] = f_i(6'h08, 0, 1, 1);          // addi $1,$0,1
    dut.Ins_Mem.data[1] = f_i(6'h05, 1, 1, 3);          // bne $1,$1,+3
    dut.Ins_Mem.data[2] = f_i(6'h08, 0, 2, 7);          // addi $2,$0,7
    dut.Ins_Mem.data[3] = f_i(6'h2b, 0, 2, 96);         // sw $2,96($0)
    dut.Ins_Mem.data[4] = f_j(4);
    release_reset();
    run(30);
    check("bne_fallthru", dut.Data_Mem.data[24], 32'd7);
    for (int i = 15; i < 24; i++)
      check($sformatf("bne_nowrite[%0d]", i), dut.Data_Mem.data[i], sent(i));
    check("j_pc_loop", {31'b0, (dut.r_pc == 32'd16 || dut.r_pc == 32'd20)}, 32'd1);

    // ---- standalone memory through the interface ----
    probe_if.addr  = 32'd4;
    probe_if.wdata = 32'h1234_5678;
    probe_if.we    = 1'b1;
    @(posedge clk);
    #1;
    probe_if.addr  = 32'd12;
    probe_if.wdata = 32'hcafe_f00d;
    @(posedge clk);
    #1;
    probe_if.we   = 1'b0;
    probe_if.addr = 32'd4;
    #1;
    check("probe_w1", probe_if.rdata, 32'h1234_5678);
    probe_if.addr = 32'd12;
    #1;
    check("probe_w3", probe_if.rdata, 32'hcafe_f00d);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mips_top.md
# mips_top

Top level of a five-stage pipelined MIPS-subset processor (IF, ID, EX, MEM, WB). It owns a word-addressed instruction memory instance `Ins_Mem` and a data memory instance `Data_Mem`. Benches preload both through hierarchical references to each instance's `data` array, then run programs to completion. There are no functional I/O ports beyond clock and reset; results are observed in `Data_Mem.data`.

## Interface
- IMEM_WORDS, 64: instruction memory depth in 32-bit words.
- DMEM_WORDS, 64: data memory depth in 32-bit words.
- clk  input  1  single system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset.

## Operation
- **Memories**
  - `Ins_Mem.data` and `Data_Mem.data` are `reg [31:0]` arrays, index 0 upward.
  - Reset never clears either array; contents loaded before or during reset must survive.
  - Instruction fetch is a combinational read of word `PC[7:2]`.
  - Data memory uses byte address; word index is `addr[7:2]`.
  - Data-memory read is combinational. Write happens at the clock edge when the MEM stage holds a `sw`.
- **Supported instructions** (standard MIPS encodings):
  - R-type `add`, `sub`, `and`, `or`, `slt`: funct 0x20, 0x22, 0x24, 0x25, 0x2A.
  - `addi` (0x08), `lw` (0x23), `sw` (0x2B), `beq` (0x04), `bne` (0x05), `j` (0x02).
  - All-zero word = nop. Any other opcode executes as a nop.
- **Arithmetic**
  - 32-bit two's complement; overflow ignored; no traps.
  - Immediates are sign-extended.
  - `slt` is a signed compare.
- **Register file**
  - 32×32. `$0` reads 0, and writes to it are discarded.
  - Written in WB. A same-cycle read of the register being written returns the new value (internal bypass).
- **Forwarding:** ALU operands are taken from EX/MEM first, then MEM/WB, then the register file. A match on `$0` is never forwarded.
- **Load-use hazard:** a `lw` in EX whose rt equals the rs or rt of the instruction in ID causes a 1-cycle stall. PC and IF/ID hold, and a bubble is inserted into ID/EX.
- **Branches**
  - Resolved in EX with predict-not-taken.
  - Target = PC+4 + (sext(imm)<<2).
  - When taken: IF/ID and ID/EX are flushed to nops, giving a 2-cycle penalty.
- **Jump:** `j` is resolved in ID with target {PC+4[31:28], imm26, 2'b00}. IF/ID is flushed, giving a 1-cycle penalty.
- **Simultaneous events:** a taken branch in EX overrides a stall request and a `j` in ID in the same cycle.

## Timing
- **Reset asserted (low):**
  - PC = 0, all pipeline registers = nop/bubble, all register-file entries = 0.
  - Memory arrays are untouched.
- **Reset deasserted:** the first fetch of word 0 occurs on the first rising edge after release. Asserting reset mid-program aborts instantly to this state.
- **Latency:** an instruction writes back 4 edges after it is fetched. Throughput is 1 instruction/cycle absent hazards.
- **Stores:** a `sw` updates `Data_Mem.data` at the edge ending its MEM stage.
- **PC past the end of memory:** fetches of words beyond loaded code read as nop unless preloaded. Programs end with a `j` self-loop.

## Structure
- **Shared package `mips_pkg`:** opcode/funct constants, ALU-op enum, and the nop word.
- **Submodules:**
  - `mips_mem`: one parameterised sync-write/async-read memory with array `data`, instantiated twice as `Ins_Mem` and `Data_Mem`.
  - Register file, ALU, and hazard/forwarding unit may be inline.

## Test plan
- **Forwarding:** `addi $1,$0,5`; `add $2,$1,$1`; `sw $2,48($0)` -> `data[12]` = 10 with no stall cycles.
- **Load-use:** `data[0]`=1; `lw $3,0($0)`; `addi $4,$3,2`; `sw $4,52($0)` -> `data[13]` = 3 and exactly one bubble.
- **Taken branch:** `beq $0,$0,+2` followed by two `addi $5` instructions, then `sw $5,56($0)` -> `data[14]` = 0 (both shadow instructions flushed).
- **`bne` not taken plus `j` self-loop:** PC holds at the loop address and there are no spurious writes to `data[15..23]`.
- **Reset:** hold reset low for 2 cycles with memories preloaded -> PC = 0 and `data[0..11]` unchanged. A mid-run reset pulse restarts from PC 0.
- **Integration:** `data[0..11]` = 1,3,5,7,9,2,4,6,8,0,0,0 with the sort program loaded -> `data[12..23]` = 0,0,0,1,2,3,4,5,6,7,8,9 within 400 cycles, and `data[0..11]` unchanged.
